// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the instruction cache.
package rv32i_pkg;
  typedef enum logic [1:0] {IDLE, REQ, REFILL, RESP} icache_state_t;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int IC_SETS = 64;
  localparam int IC_LINE_WORDS = 4;
  localparam int IC_ADDR_W = 32;
  localparam int IC_OB = $clog2(IC_LINE_WORDS);
  localparam int IC_IB = $clog2(IC_SETS);
  localparam int IC_TB = IC_ADDR_W - IC_OB - IC_IB;
endpackage

// File: rtl/icache_tag_array.sv
// icache_tag_array: per-set valid/tag storage with sync clear and combinational hit compare.
module icache_tag_array #(
  parameter int SETS = 64,
  parameter int IB = 6,
  parameter int TB = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [IB-1:0] rd_idx,
  input  logic [TB-1:0] rd_tag,
  output logic          hit,
  input  logic          we,
  input  logic [IB-1:0] wr_idx,
  input  logic [TB-1:0] wr_tag
);
  logic [SETS-1:0] valid;
  logic [TB-1:0] tags [SETS];
  always_ff @(posedge clk)
    if (!rstn) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (we) tags[wr_idx] <= wr_tag;
  assign hit = valid[rd_idx] && tags[rd_idx] == rd_tag;
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with single-line refill on miss.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module inst_cache import rv32i_pkg::*; #(
  parameter int SETS = IC_SETS,
  parameter int LINE_WORDS = IC_LINE_WORDS,
  parameter int ADDR_W = IC_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              read_enb,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [31:0]       inst_out,
  output logic              inst_valid,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = ADDR_W - OB - IB;
  icache_state_t state, state_n;
  logic [31:0] data_q [SETS*LINE_WORDS];
  logic [OB-1:0] beat, lat_off;
  logic [OB-1:0] off;
  logic [IB-1:0] idx, lat_idx;
  logic [TB-1:0] tag, lat_tag;
  logic hit, lookup, hit_rd, miss, fill, last, done;
  assign off = read_addr[OB-1:0];
  assign idx = read_addr[OB+:IB];
  assign tag = read_addr[ADDR_W-1:OB+IB];
  assign lat_idx = mem_req_addr[OB+:IB];
  assign lat_tag = mem_req_addr[ADDR_W-1:OB+IB];
  assign lookup = state == IDLE && read_enb;
  assign hit_rd = lookup && hit;
  assign miss = lookup && !hit;
  assign fill = state == REFILL && mem_rsp_valid;
  assign last = beat == OB'(LINE_WORDS-1);
  assign done = fill && last;
  icache_tag_array #(.SETS(SETS), .IB(IB), .TB(TB)) u_tags (
    .clk(clk), .rstn(rstn), .rd_idx(idx), .rd_tag(tag), .hit(hit),
    .we(done), .wr_idx(lat_idx), .wr_tag(lat_tag)
  );
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE   ? (miss ? REQ : IDLE) :
              state == REQ    ? (mem_req_ready ? REFILL : REQ) :
              state == REFILL ? (done ? RESP : REFILL) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!rstn) begin
      beat <= '0;
      stall <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      inst_out <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      stall <= state_n == REQ || state_n == REFILL;
      mem_req_valid <= state_n == REQ;
      if (miss) mem_req_addr <= {read_addr[ADDR_W-1:OB], {OB{1'b0}}};
      if (fill) beat <= beat + OB'(1);
      inst_valid <= hit_rd || done;
      if (hit_rd) inst_out <= data_q[{idx, off}];
      // the requested word may be the beat being written this very edge
      else if (done) inst_out <= lat_off == beat ? mem_rsp_data : data_q[{lat_idx, lat_off}];
    end
  always_ff @(posedge clk) begin
    if (miss) lat_off <= off;
    if (fill) data_q[{lat_idx, beat}] <= mem_rsp_data;
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk)
    if (!rstn) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (hit_rd) hit_count <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: table vectors, corner sequences and random fetches against a set/tag model.
module tb_inst_cache;
  localparam int LW = 4;
  localparam int NS = 64;
  logic clk = 1'b0, rstn = 1'b0, read_enb = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] read_addr = '0, mem_rsp_data = '0;
  logic [31:0] inst_out, mem_req_addr;
  logic inst_valid, stall, mem_req_valid;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int passed = 0, total = 0, exp_hits = 0, exp_misses = 0;
  bit mv [NS];
  logic [31:0] mt [NS];
  typedef struct {logic [31:0] a; bit hit; int rdy; bit stray;} vec_t;
  vec_t tbl [12];

  inst_cache dut (
    .clk(clk), .rstn(rstn), .read_enb(read_enb), .read_addr(read_addr),
    .inst_out(inst_out), .inst_valid(inst_valid), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    int unsigned i = (a / LW) % NS;
    return mv[i] && mt[i] == a / (LW * NS);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) mv[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int rdy, input bit stray);
    logic [31:0] base = a & ~32'(LW - 1);
    bit bad = 1'b0;
    read_enb = 1'b1;
    read_addr = a;
    @(negedge clk);
    read_enb = 1'b0;
    read_addr = $urandom;
    chk("req_valid", mem_req_valid, !exp_hit);
    if (exp_hit) begin
      exp_hits++;
      chk("hit_valid", inst_valid, 1);
      chk("hit_data", inst_out, mw(a));
      chk("hit_stall", stall, 0);
      return;
    end
    exp_misses++;
    chk("req_addr", mem_req_addr, base);
    chk("miss_valid", inst_valid, 0);
    for (int i = 0; i < rdy; i++) begin
      if (!mem_req_valid || mem_req_addr !== base || !stall) bad = 1'b1;
      mem_rsp_valid = stray;
      mem_rsp_data = 32'hDEADBEEF;
      @(negedge clk);
    end
    if (!mem_req_valid || mem_req_addr !== base || !stall) bad = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < LW; b++) begin
      if (mem_req_valid || !stall) bad = 1'b1;
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        if (mem_req_valid || !stall) bad = 1'b1;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data = mw(base + 32'(b));
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    chk("refill_stall_seq", bad, 0);
    chk("resp_valid", inst_valid, 1);
    chk("resp_data", inst_out, mw(a));
    chk("resp_stall", stall, 0);
    mv[(a / LW) % NS] = 1'b1;
    mt[(a / LW) % NS] = a / (LW * NS);
    @(negedge clk);
    chk("post_resp_valid", inst_valid, 0);
  endtask

  initial begin
    tbl[0]  = '{32'h10, 1'b0, 0, 1'b0};
    tbl[1]  = '{32'h11, 1'b1, 0, 1'b0};
    tbl[2]  = '{32'h13, 1'b1, 0, 1'b0};
    tbl[3]  = '{32'h110, 1'b0, 5, 1'b1};
    tbl[4]  = '{32'h10, 1'b0, 0, 1'b0};
    tbl[5]  = '{32'h112, 1'b0, 1, 1'b0};
    tbl[6]  = '{32'h33, 1'b0, 2, 1'b1};
    tbl[7]  = '{32'h30, 1'b1, 0, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 1'b0, 0, 1'b0};
    tbl[9]  = '{32'hFFFFFFFC, 1'b1, 0, 1'b0};
    tbl[10] = '{32'hFC, 1'b0, 0, 1'b0};
    tbl[11] = '{32'hFFFFFFFE, 1'b0, 3, 1'b1};
    clear_model();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("rst_inst_out", inst_out, 32'h13);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("idle_rsp_ignored", stall, 0);
    for (int i = 0; i < 12; i++) fetch(tbl[i].a, tbl[i].hit, tbl[i].rdy, tbl[i].stray);
    read_enb = 1'b1;
    read_addr = 32'h30;
    for (int k = 0; k < LW; k++) begin
      @(negedge clk);
      exp_hits++;
      chk("b2b_valid", inst_valid, 1);
      chk("b2b_data", inst_out, mw(32'h30 + 32'(k)));
      if (k < LW - 1) read_addr = 32'h31 + 32'(k);
      else read_enb = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_valid", inst_valid, 0);
    chk("b2b_hold_data", inst_out, mw(32'h33));
    read_enb = 1'b1;
    read_addr = 32'h200;
    @(negedge clk);
    read_enb = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hBAD00000 + 32'(b);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    clear_model();
    chk("midrst_req_valid", mem_req_valid, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_inst_out", inst_out, 32'h13);
    fetch(32'h200, 1'b0, 1, 1'b0);
    fetch(32'h201, 1'b1, 0, 1'b0);
    fetch(32'h30, 1'b0, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 7) == 0 ? 32'hFFFFFF00 | 32'($urandom_range(0, 31))
                                    : 32'($urandom_range(0, 2)) * 256 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      fetch(a, mhit(a), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
